// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//
// Stall/flush controller for the 5-stage core. Each cycle it decides whether
// the pipeline registers capture, hold or clear. It handles load-use stalls,
// taken-branch flushes and multi-cycle data-memory waits. A watchdog locks the
// block into ERROR if a memory access never completes. A saturating counter
// records how many cycles the PC register was held.
//
// Ports
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   rs1D_i       decode source register 1
//   rs2D_i       decode source register 2
//   rdE_i        execute destination register
//   mem_readE_i  execute instruction is a load
//   pc_srcE_i    taken branch/jump resolved in execute
//   mem_reqM_i   memory stage holds a valid data-memory access
//   mem_ackM_i   data memory completes the access this cycle
//   stallF_o     hold PC register
//   stallD_o     hold fetch->decode register
//   stallE_o     hold decode->execute register
//   stallM_o     hold execute->memory register
//   flushD_o     clear fetch->decode register
//   flushE_o     clear decode->execute register
//   flushW_o     clear memory->writeback register
//   mem_err_o    sticky memory timeout flag
//   stall_cnt_o  saturating count of cycles with stallF_o high
//
// State     | meaning
// ----------+------------------------------------------------------------
// ST_RUN    | normal flow; hazards resolved by priority miss > branch > lu
// ST_MEM_WAIT| data access outstanding; pipeline frozen, watchdog counting
// ST_ERROR  | access timed out; pipeline frozen until reset
// ----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT    = 8,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdE_i,
    input  logic                      mem_readE_i,
    input  logic                      pc_srcE_i,
    input  logic                      mem_reqM_i,
    input  logic                      mem_ackM_i,
    output logic                      stallF_o,
    output logic                      stallD_o,
    output logic                      stallE_o,
    output logic                      stallM_o,
    output logic                      flushD_o,
    output logic                      flushE_o,
    output logic                      flushW_o,
    output logic                      mem_err_o,
    output logic [CNT_WIDTH-1:0]      stall_cnt_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic lu;
    logic miss;

    assign lu   = mem_readE_i && (rdE_i != '0) &&
                  ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));
    assign miss = mem_reqM_i && !mem_ackM_i;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        stallF_o   = 1'b0;
        stallD_o   = 1'b0;
        stallE_o   = 1'b0;
        stallM_o   = 1'b0;
        flushD_o   = 1'b0;
        flushE_o   = 1'b0;
        flushW_o   = 1'b0;

        if (!rst_n_i) begin
            // Keep bubbles flowing into the pipe while reset is held.
            flushD_o = 1'b1;
            flushE_o = 1'b1;
            flushW_o = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (miss) begin
                        stallF_o   = 1'b1;
                        stallD_o   = 1'b1;
                        stallE_o   = 1'b1;
                        stallM_o   = 1'b1;
                        flushW_o   = 1'b1;
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = '0;
                    end else if (pc_srcE_i) begin
                        // Decode holds a wrong-path instruction, so a
                        // load-use match there is irrelevant.
                        flushD_o = 1'b1;
                        flushE_o = 1'b1;
                    end else if (lu) begin
                        stallF_o = 1'b1;
                        stallD_o = 1'b1;
                        flushE_o = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ackM_i || !mem_reqM_i) begin
                        // Completion or abort: release the pipe; D/E were
                        // held so hazards get evaluated again in RUN.
                        state_d = ST_RUN;
                    end else begin
                        stallF_o = 1'b1;
                        stallD_o = 1'b1;
                        stallE_o = 1'b1;
                        stallM_o = 1'b1;
                        flushW_o = 1'b1;
                        if (wait_cnt_q == WAIT_LAST) begin
                            state_d = ST_ERROR;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                        end
                    end
                end
                ST_ERROR: begin
                    stallF_o = 1'b1;
                    stallD_o = 1'b1;
                    stallE_o = 1'b1;
                    stallM_o = 1'b1;
                    flushW_o = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mem_err_o   <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (state_d == ST_ERROR) begin
                mem_err_o <= 1'b1;
            end
            if (stallF_o && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Bench for hazard_ctrl: a table of single-cycle RUN vectors, hand-written
// multi-cycle sequences (memory wait, timeout, reset mid-wait, counter
// saturation) and a randomized phase checked against a cycle-level model that
// tracks the length of the current memory-stall episode.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int RW = 5;
    localparam int TO = 8;

    // Output bundle order: {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
    localparam logic [6:0] O_NONE   = 7'b0000_000;
    localparam logic [6:0] O_FREEZE = 7'b1111_001;
    localparam logic [6:0] O_BRANCH = 7'b0000_110;
    localparam logic [6:0] O_LU     = 7'b1100_010;
    localparam logic [6:0] O_RESET  = 7'b0000_111;

    typedef struct packed {
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic [RW-1:0] rd;
        logic          mr;
        logic          pc;
        logic          req;
        logic          ack;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [6:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [RW-1:0] rs1, rs2, rd;
    logic          mr, pc, req, ack;
    logic          stallF, stallD, stallE, stallM, flushD, flushE, flushW;
    logic          mem_err;
    logic [31:0]   stall_cnt;

    logic          s_rst_n, s_req, s_ack;
    logic          s_stallF, s_stallD, s_stallE, s_stallM;
    logic          s_flushD, s_flushE, s_flushW, s_err;
    logic [3:0]    s_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: length of the current stall episode (0 = none), sticky error,
    // and the expected counter value.
    int          m_len;
    bit          m_err;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_WIDTH(RW), .MEM_TIMEOUT(TO), .CNT_WIDTH(32)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .rs1D_i(rs1), .rs2D_i(rs2), .rdE_i(rd),
        .mem_readE_i(mr), .pc_srcE_i(pc), .mem_reqM_i(req), .mem_ackM_i(ack),
        .stallF_o(stallF), .stallD_o(stallD), .stallE_o(stallE), .stallM_o(stallM),
        .flushD_o(flushD), .flushE_o(flushE), .flushW_o(flushW),
        .mem_err_o(mem_err), .stall_cnt_o(stall_cnt)
    );

    hazard_ctrl #(.REG_ADDR_WIDTH(RW), .MEM_TIMEOUT(2), .CNT_WIDTH(4)) u_sat (
        .clk_i(clk), .rst_n_i(s_rst_n),
        .rs1D_i('0), .rs2D_i('0), .rdE_i('0),
        .mem_readE_i(1'b0), .pc_srcE_i(1'b0), .mem_reqM_i(s_req), .mem_ackM_i(s_ack),
        .stallF_o(s_stallF), .stallD_o(s_stallD), .stallE_o(s_stallE), .stallM_o(s_stallM),
        .flushD_o(s_flushD), .flushE_o(s_flushE), .flushW_o(s_flushW),
        .mem_err_o(s_err), .stall_cnt_o(s_cnt)
    );

    wire [6:0] dut_o = {stallF, stallD, stallE, stallM, flushD, flushE, flushW};
    wire [6:0] sat_o = {s_stallF, s_stallD, s_stallE, s_stallM, s_flushD, s_flushE, s_flushW};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] model_out(input in_t v);
        bit lu, miss;
        lu   = v.mr && (v.rd != 0) && (v.rd == v.rs1 || v.rd == v.rs2);
        miss = v.req && !v.ack;
        if (m_err)            return O_FREEZE;
        if (m_len > 0)        return (v.ack || !v.req) ? O_NONE : O_FREEZE;
        if (miss)             return O_FREEZE;
        if (v.pc)             return O_BRANCH;
        if (lu)               return O_LU;
        return O_NONE;
    endfunction

    task automatic model_edge(input in_t v);
        logic [6:0] o;
        o = model_out(v);
        if (o[6] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (!m_err) begin
            if (m_len > 0) begin
                if (v.ack || !v.req) m_len = 0;
                else begin
                    m_len++;
                    if (m_len == 1 + TO) m_err = 1;
                end
            end else if (v.req && !v.ack) begin
                m_len = 1;
            end
        end
    endtask

    task automatic drive(input in_t v);
        rs1 = v.rs1; rs2 = v.rs2; rd = v.rd;
        mr = v.mr; pc = v.pc; req = v.req; ack = v.ack;
    endtask

    // Called in the low phase; returns at the next falling edge.
    task automatic step(input in_t v, input logic [6:0] exp_o, input bit chk);
        drive(v);
        #1;
        check("outputs_vs_model", {25'd0, dut_o}, {25'd0, model_out(v)});
        if (chk) check("outputs_vs_expected", {25'd0, dut_o}, {25'd0, exp_o});
        @(posedge clk);
        model_edge(v);
        #1;
        check("mem_err_vs_model", {31'd0, mem_err}, {31'd0, m_err});
        check("stall_cnt_vs_model", stall_cnt, m_cnt);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_len = 0; m_err = 0; m_cnt = 0;
        #1;
        check("reset_outputs", {25'd0, dut_o}, {25'd0, O_RESET});
        check("reset_mem_err", {31'd0, mem_err}, 32'd0);
        check("reset_stall_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic in_t mk(input int r1, input int r2, input int d,
                               input bit m, input bit p, input bit q, input bit a);
        in_t v;
        v.rs1 = RW'(r1); v.rs2 = RW'(r2); v.rd = RW'(d);
        v.mr = m; v.pc = p; v.req = q; v.ack = a;
        return v;
    endfunction

    vec_t tbl [10];
    in_t  v;

    initial begin
        rst_n = 1'b0; s_rst_n = 1'b0; s_req = 1'b0; s_ack = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0));
        m_len = 0; m_err = 0; m_cnt = 0;
        #2;
        check("initial_reset_outputs", {25'd0, dut_o}, {25'd0, O_RESET});
        check("initial_reset_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle RUN vectors; none of them starts a memory wait.
        tbl[0] = '{mk(1, 5, 5, 1, 0, 0, 0), O_LU};
        tbl[1] = '{mk(1, 5, 0, 1, 0, 0, 0), O_NONE};
        tbl[2] = '{mk(0, 0, 0, 1, 0, 0, 0), O_NONE};
        tbl[3] = '{mk(1, 5, 5, 1, 1, 0, 0), O_BRANCH};
        tbl[4] = '{mk(7, 2, 7, 1, 0, 0, 0), O_LU};
        tbl[5] = '{mk(7, 2, 7, 0, 0, 0, 0), O_NONE};
        tbl[6] = '{mk(3, 4, 9, 1, 0, 0, 0), O_NONE};
        tbl[7] = '{mk(0, 0, 0, 0, 1, 0, 0), O_BRANCH};
        tbl[8] = '{mk(1, 5, 5, 1, 0, 1, 1), O_LU};
        tbl[9] = '{mk(3, 3, 3, 0, 1, 1, 1), O_BRANCH};
        for (int i = 0; i < 10; i++) step(tbl[i].in, tbl[i].exp, 1'b1);

        // Memory wait with ack on the 4th cycle.
        do_reset();
        for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 0, 1, 0), O_FREEZE, 1'b1);
        step(mk(0, 0, 0, 0, 0, 1, 1), O_NONE, 1'b1);
        check("memwait_stall_cnt", stall_cnt, 32'd3);
        step(mk(1, 5, 5, 1, 0, 0, 0), O_LU, 1'b1);

        // Abort: request dropped while waiting.
        do_reset();
        step(mk(0, 0, 0, 0, 0, 1, 0), O_FREEZE, 1'b1);
        step(mk(0, 0, 0, 0, 0, 0, 0), O_NONE, 1'b1);
        step(mk(0, 0, 0, 0, 1, 0, 0), O_BRANCH, 1'b1);

        // Timeout: 9 stalled cycles, error rises on the 9th edge.
        do_reset();
        for (int i = 0; i < 1 + TO; i++) begin
            step(mk(0, 0, 0, 0, 0, 1, 0), O_FREEZE, 1'b1);
            check("timeout_err_edge", {31'd0, mem_err}, (i == TO) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 4; i++) step(mk(1, 5, 5, 1, 1, 1, 1), O_FREEZE, 1'b1);
        check("error_sticky", {31'd0, mem_err}, 32'd1);
        check("error_stall_cnt", stall_cnt, 32'd13);

        // Reset dropped during the 2nd wait cycle.
        do_reset();
        step(mk(0, 0, 0, 0, 0, 1, 0), O_FREEZE, 1'b1);
        step(mk(0, 0, 0, 0, 0, 1, 0), O_FREEZE, 1'b1);
        drive(mk(0, 0, 0, 0, 0, 1, 0));
        #1;
        check("wait2_outputs", {25'd0, dut_o}, {25'd0, O_FREEZE});
        do_reset();
        step(mk(1, 5, 5, 1, 0, 0, 0), O_LU, 1'b1);

        // Counter saturation on the 4-bit instance.
        @(negedge clk);
        s_rst_n = 1'b1; s_req = 1'b1; s_ack = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            check("sat_cnt_progress", {28'd0, s_cnt}, (k < 15) ? k : 15);
        end
        check("sat_error_flag", {31'd0, s_err}, 32'd1);
        check("sat_outputs", {25'd0, sat_o}, {25'd0, O_FREEZE});
        @(negedge clk);
        s_rst_n = 1'b0;
        #1;
        check("sat_reset_cnt", {28'd0, s_cnt}, 32'd0);

        // Randomized phase against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v.rs1 = RW'($urandom_range(0, 3));
            v.rs2 = RW'($urandom_range(0, 3));
            v.rd  = RW'($urandom_range(0, 3));
            v.mr  = ($urandom_range(0, 1) == 1);
            v.pc  = ($urandom_range(0, 3) == 0);
            v.req = ($urandom_range(0, 1) == 1);
            v.ack = ($urandom_range(0, 3) != 0);
            if (i > 300) v.ack = ($urandom_range(0, 7) == 0);
            step(v, O_NONE, 1'b0);
            if (m_err && $urandom_range(0, 3) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall/flush controller for the 5-stage core. Every cycle it decides whether the fetch→decode, decode→execute, execute→memory and memory→writeback pipeline registers capture, hold or clear. It covers load-use stalls, taken-branch flushes and multi-cycle data-memory waits, with a timeout watchdog. It also keeps a saturating stall-cycle performance counter.

## Interface
- `REG_ADDR_WIDTH`, default 5: register index width.
- `MEM_TIMEOUT`, default 8: maximum MEM_WAIT cycles before error; must be ≥2.
- `CNT_WIDTH`, default 32: stall counter width.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `rs1D_i`  in  REG_ADDR_WIDTH  source register 1 of the instruction in decode.
- `rs2D_i`  in  REG_ADDR_WIDTH  source register 2 of the instruction in decode.
- `rdE_i`  in  REG_ADDR_WIDTH  destination register of the instruction in execute.
- `mem_readE_i`  in  1  instruction in execute is a load.
- `pc_srcE_i`  in  1  taken branch/jump resolved in execute.
- `mem_reqM_i`  in  1  memory stage holds a valid data-memory access.
- `mem_ackM_i`  in  1  data memory completes the access this cycle.
- `stallF_o`  out  1  hold PC register.
- `stallD_o`  out  1  hold fetch→decode register.
- `stallE_o`  out  1  hold decode→execute register.
- `stallM_o`  out  1  hold execute→memory register.
- `flushD_o`  out  1  clear fetch→decode register (bubble).
- `flushE_o`  out  1  clear decode→execute register.
- `flushW_o`  out  1  clear memory→writeback register.
- `mem_err_o`  out  1  sticky memory timeout flag.
- `stall_cnt_o`  out  CNT_WIDTH  count of cycles with `stallF_o` high.

## Operation
- State machine states: RUN, MEM_WAIT, ERROR. Internal counter `wait_cnt` is ceil(log2(MEM_TIMEOUT)) bits wide.
- Stall/flush outputs are combinational from the state and inputs. `mem_err_o`, `stall_cnt_o`, the state and `wait_cnt` are registered.
- Reset (`rst_n_i`=0) puts the block in RUN with `wait_cnt`=0, `mem_err_o`=0 and `stall_cnt_o`=0. While reset is asserted, `flushD_o`=`flushE_o`=`flushW_o`=1 and all stalls are 0.
- Load-use hazard: `lu` = `mem_readE_i` & (`rdE_i`≠0) & (`rdE_i`==`rs1D_i` | `rdE_i`==`rs2D_i`).
- Memory miss: `miss` = `mem_reqM_i` & !`mem_ackM_i`.
- RUN, priority order:
  1. `miss`: assert all four stalls plus `flushW_o`; suppress every other flush. Next state is MEM_WAIT with `wait_cnt`=0.
  2. `pc_srcE_i`: assert `flushD_o` and `flushE_o`, no stalls. Branch beats load-use because the decode instruction is wrong-path.
  3. `lu`: assert `stallF_o`, `stallD_o` and `flushE_o`.
  4. Otherwise all outputs are 0.
- MEM_WAIT:
  - `mem_ackM_i`=1 or `mem_reqM_i`=0 (completion or abort): all stalls and flushes are 0 this cycle. Next state is RUN. Branch and load-use are not evaluated in this cycle; they are re-evaluated in RUN next cycle because stages E and D were held.
  - Otherwise: same outputs as the `miss` case above. If `wait_cnt`==MEM_TIMEOUT-1, next state is ERROR; else `wait_cnt` increments.
- ERROR: all four stalls and `flushW_o` are held high and `mem_err_o`=1. The state only exits on reset.
- `stall_cnt_o` increments on each edge where `stallF_o`=1. It saturates at all-ones and never wraps.

## Timing
- Stall/flush response has zero-cycle latency: it is combinational, so the same-edge pipeline-register update is affected.
- A miss in RUN adds one stall cycle in RUN, then stalls continue until the ack cycle. The ack cycle itself is unstalled.
- The maximum number of stalled cycles before ERROR is 1+MEM_TIMEOUT. `mem_err_o` rises on the edge that enters ERROR.
- Asynchronous reset mid-MEM_WAIT or in ERROR returns the block immediately to the reset values.
- `stall_cnt_o` lags `stallF_o` by one edge.

## Test plan
- Load-use: `mem_readE_i`=1, `rdE_i`=5, `rs2D_i`=5, no miss → `stallF_o`=`stallD_o`=`flushE_o`=1 for one cycle. Repeat with `rdE_i`=0 → no stall.
- Branch vs load-use: `pc_srcE_i`=1 together with the load-use condition above → `flushD_o`=`flushE_o`=1, `stallF_o`=0.
- Memory wait: `mem_reqM_i`=1, ack raised on the 4th cycle → stalls plus `flushW_o` high for 3 cycles, 0 on the ack cycle, back in RUN. `stall_cnt_o` reads 3.
- Timeout: MEM_TIMEOUT=8, `mem_reqM_i`=1, no ack → 9 stalled cycles, then `mem_err_o`=1. Stalls stay high indefinitely.
- Reset mid-MEM_WAIT: drop `rst_n_i` during the 2nd wait cycle → all flushes 1, stalls 0, `stall_cnt_o`=0, RUN after release.
- Counter saturation: CNT_WIDTH=4, hold ERROR for 20 cycles → `stall_cnt_o` stops at 15.
